// File: rtl/scr1_tcm_sp_arb.sv
// Arbiter sharing one single-port TCM SRAM between the instruction and data ports.
// dmem has priority, but imem is let through after DMEM_STREAK_MAX data grants in a row.
module scr1_tcm_sp_arb #(
    parameter int unsigned SCR1_TCM_SIZE   = 32'h00010000,
    parameter int unsigned DMEM_STREAK_MAX = 4,
    parameter int unsigned AW              = $clog2(SCR1_TCM_SIZE) - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_req,
    output logic          imem_req_ack,
    input  logic [31:0]   imem_addr,
    output logic [31:0]   imem_rdata,
    output logic [1:0]    imem_resp,
    input  logic          dmem_req,
    output logic          dmem_req_ack,
    input  logic          dmem_cmd,
    input  logic [1:0]    dmem_width,
    input  logic [31:0]   dmem_addr,
    input  logic [31:0]   dmem_wdata,
    output logic [31:0]   dmem_rdata,
    output logic [1:0]    dmem_resp,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_be,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int unsigned SW         = $clog2(DMEM_STREAK_MAX + 1);
    localparam logic [SW-1:0] STRK_MAX = SW'(DMEM_STREAK_MAX);
    localparam logic [31:0] TCM_SIZE   = 32'(SCR1_TCM_SIZE);

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_RDY_OK = 2'b01;
    localparam logic [1:0] RESP_RDY_ER = 2'b10;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    logic [SW-1:0] streak_q, streak_d;

    logic          rsp_vld_q, rsp_dmem_q, rsp_err_q, rsp_rd_q;
    logic [1:0]    rsp_off_q;

    logic          dmem_gnt, imem_gnt, any_gnt;
    logic          dmem_err, imem_err, sel_err;
    logic [31:0]   sel_addr;
    logic [31:0]   rd_shifted;
    logic [1:0]    resp_val;

    assign dmem_gnt = !rst && dmem_req && !(imem_req && (streak_q == STRK_MAX));
    assign imem_gnt = !rst && imem_req && !dmem_gnt;
    assign any_gnt  = dmem_gnt || imem_gnt;

    assign dmem_req_ack = dmem_gnt;
    assign imem_req_ack = imem_gnt;

    always_comb begin
        dmem_err = (dmem_addr >= TCM_SIZE);
        unique case (dmem_width)
            W_BYTE:  ;
            W_HALF:  if (dmem_addr[0]) dmem_err = 1'b1;
            W_WORD:  if (dmem_addr[1:0] != 2'b00) dmem_err = 1'b1;
            default: dmem_err = 1'b1;
        endcase
    end

    assign imem_err = (imem_addr >= TCM_SIZE) || (imem_addr[1:0] != 2'b00);
    assign sel_addr = dmem_gnt ? dmem_addr : imem_addr;
    assign sel_err  = dmem_gnt ? dmem_err : imem_err;

    always_comb begin
        ram_en    = any_gnt && !sel_err;
        ram_we    = ram_en && dmem_gnt && dmem_cmd;
        ram_addr  = sel_addr[AW+1:2];
        ram_be    = 4'b0000;
        ram_wdata = dmem_wdata;
        if (ram_en) begin
            if (imem_gnt) begin
                ram_be = 4'b1111;
            end else begin
                unique case (dmem_width)
                    W_WORD: ram_be = 4'b1111;
                    W_HALF: begin
                        ram_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                        ram_wdata = {2{dmem_wdata[15:0]}};
                    end
                    W_BYTE: begin
                        ram_be    = 4'b0001 << dmem_addr[1:0];
                        ram_wdata = {4{dmem_wdata[7:0]}};
                    end
                    default: ram_be = 4'b0000;
                endcase
            end
        end
    end

    // Streak only builds while imem is actually waiting for the array.
    always_comb begin
        streak_d = streak_q;
        if (!imem_req || imem_gnt) begin
            streak_d = '0;
        end else if (dmem_gnt && (streak_q != STRK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_dmem_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rd_q   <= 1'b0;
            rsp_off_q  <= 2'b00;
        end else begin
            streak_q   <= streak_d;
            rsp_vld_q  <= any_gnt;
            rsp_dmem_q <= dmem_gnt;
            rsp_err_q  <= sel_err;
            rsp_rd_q   <= imem_gnt || !dmem_cmd;
            rsp_off_q  <= sel_addr[1:0];
        end
    end

    // Reset also masks a response already in flight from the last pre-reset grant.
    always_comb begin
        imem_resp  = RESP_NOTRDY;
        dmem_resp  = RESP_NOTRDY;
        imem_rdata = '0;
        dmem_rdata = '0;
        rd_shifted = ram_rdata >> {rsp_off_q, 3'b000};
        resp_val   = rsp_err_q ? RESP_RDY_ER : RESP_RDY_OK;
        if (!rst && rsp_vld_q) begin
            if (rsp_dmem_q) begin
                dmem_resp = resp_val;
                if (!rsp_err_q && rsp_rd_q) dmem_rdata = rd_shifted;
            end else begin
                imem_resp = resp_val;
                if (!rsp_err_q && rsp_rd_q) imem_rdata = rd_shifted;
            end
        end
    end

endmodule

// File: tb/tb_scr1_tcm_sp_arb.sv
// Directed bench for scr1_tcm_sp_arb: byte-level memory/grant model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_scr1_tcm_sp_arb;

    localparam logic [31:0] TCM     = 32'h00010000;
    localparam int          STRKMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_req_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [1:0]  imem_resp;
    logic        dmem_req, dmem_req_ack, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    scr1_tcm_sp_arb dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_req_ack(imem_req_ack), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM behind the arbiter: data appears one cycle after ram_en.
    logic [31:0] sram [0:16383];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                for (int k = 0; k < 4; k++)
                    if (ram_be[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
            ram_rdata <= sram[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned ref_mem [0:65535];
    int           m_streak = 0;
    bit           p_vld = 0, p_dmem = 0, p_err = 0, p_rd = 0;
    logic [31:0]  p_data = '0;

    always @(negedge clk) begin : model
        bit          d_win, i_win, d_err, i_err, e_en, g_err;
        logic [1:0]  e_iresp, e_dresp, rv;
        logic [31:0] e_ird, e_drd, a, w, base;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          nb;

        e_iresp = 2'b00; e_dresp = 2'b00; e_ird = '0; e_drd = '0;
        d_win = 0; i_win = 0;
        if (!rst) begin
            if (p_vld) begin
                rv = p_err ? 2'b10 : 2'b01;
                if (p_dmem) begin
                    e_dresp = rv;
                    if (p_rd && !p_err) e_drd = p_data;
                end else begin
                    e_iresp = rv;
                    if (p_rd && !p_err) e_ird = p_data;
                end
            end
            d_win = dmem_req && !(imem_req && m_streak >= STRKMAX);
            i_win = imem_req && !d_win;
        end

        d_err = (dmem_addr >= TCM) || (dmem_width == 2'b11) ||
                (dmem_width == 2'b01 && dmem_addr % 2 != 0) ||
                (dmem_width == 2'b10 && dmem_addr % 4 != 0);
        i_err = (imem_addr >= TCM) || (imem_addr % 4 != 0);
        g_err = d_win ? d_err : i_err;
        a     = d_win ? dmem_addr : imem_addr;
        e_en  = (d_win || i_win) && !g_err;

        nb = 4; e_be = 4'hF; e_wd = dmem_wdata;
        if (d_win && dmem_width == 2'b01) begin
            nb = 2; e_be = (a % 4 >= 2) ? 4'hC : 4'h3; e_wd = {2{dmem_wdata[15:0]}};
        end else if (d_win && dmem_width == 2'b00) begin
            nb = 1; e_be = 4'(1 << (a % 4)); e_wd = {4{dmem_wdata[7:0]}};
        end

        chk("m_iack", imem_req_ack, i_win);
        chk("m_dack", dmem_req_ack, d_win);
        chk("m_ram_en", ram_en, e_en);
        chk("m_iresp", imem_resp, e_iresp);
        chk("m_dresp", dmem_resp, e_dresp);
        chk("m_irdata", imem_rdata, e_ird);
        chk("m_drdata", dmem_rdata, e_drd);
        if (e_en) begin
            chk("m_ram_we", ram_we, d_win && dmem_cmd);
            chk("m_ram_addr", 32'(ram_addr), a / 4);
            chk("m_ram_be", ram_be, e_be);
            if (d_win && dmem_cmd) chk("m_ram_wdata", ram_wdata, e_wd);
        end

        if (rst) begin
            p_vld = 0; m_streak = 0;
        end else begin
            p_vld  = d_win || i_win;
            p_dmem = d_win;
            p_err  = g_err;
            p_rd   = i_win || !dmem_cmd;
            p_data = '0;
            if (e_en && p_rd) begin
                base   = a & ~32'd3;
                w      = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
                p_data = w >> (8 * (a % 4));
            end else if (e_en) begin
                for (int k = 0; k < nb; k++) ref_mem[a+k] = 8'(dmem_wdata >> (8 * k));
            end
            if (!imem_req || i_win) m_streak = 0;
            else if (d_win && m_streak < STRKMAX) m_streak++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dc,
                       input logic [1:0] dw, input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk); #1;
        imem_req = ir; imem_addr = ia;
        dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
    endtask

    task automatic idle();
        drv(0, 32'h0, 0, 0, 2'b10, 32'h0, 32'h0);
    endtask

    task automatic contend();
        drv(1, 32'h14, 1, 0, 2'b10, 32'h10, 32'h0);
    endtask

    initial begin
        rst = 1; imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_cmd = 0;
        dmem_width = 2'b10; dmem_addr = 0; dmem_wdata = 0;

        drv(1, 32'h0, 1, 0, 2'b10, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_iack", imem_req_ack, 0);
        chk("rst_dack", dmem_req_ack, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_dresp", dmem_resp, 2'b00);
        chk("rst_iresp", imem_resp, 2'b00);
        idle();

        drv(0, 0, 1, 1, 2'b10, 32'h10, 32'hDEADBEEF); rst = 0;
        @(negedge clk);
        chk("wr_ack", dmem_req_ack, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", 32'(ram_addr), 32'h4);
        chk("wr_be", ram_be, 4'hF);
        drv(0, 0, 1, 0, 2'b10, 32'h10, 32'h0);
        @(negedge clk);
        chk("wr_resp", dmem_resp, 2'b01);
        chk("wr_rdata", dmem_rdata, 32'h0);
        idle();
        @(negedge clk);
        chk("rd_resp", dmem_resp, 2'b01);
        chk("rd_data", dmem_rdata, 32'hDEADBEEF);

        drv(0, 0, 1, 1, 2'b00, 32'h13, 32'h123456A5);
        @(negedge clk);
        chk("bw_be", ram_be, 4'b1000);
        chk("bw_wdata", ram_wdata, 32'hA5A5A5A5);
        drv(0, 0, 1, 0, 2'b00, 32'h13, 32'h0);
        idle();
        @(negedge clk);
        chk("br_byte", dmem_rdata[7:0], 8'hA5);
        chk("br_word", dmem_rdata, 32'h000000A5);

        drv(0, 0, 1, 1, 2'b01, 32'h16, 32'hABCD1234);
        @(negedge clk);
        chk("hw_be", ram_be, 4'b1100);
        chk("hw_wdata", ram_wdata, 32'h12341234);
        drv(0, 0, 1, 0, 2'b01, 32'h16, 32'h0);
        idle();
        @(negedge clk);
        chk("hr_data", dmem_rdata, 32'h00001234);

        drv(0, 0, 1, 0, 2'b01, 32'h01, 32'h0);
        @(negedge clk);
        chk("herr_ack", dmem_req_ack, 1);
        chk("herr_en", ram_en, 0);
        drv(0, 0, 1, 0, 2'b10, 32'h00010000, 32'h0);
        @(negedge clk);
        chk("herr_resp", dmem_resp, 2'b10);
        chk("oob_en", ram_en, 0);
        drv(1, 32'h2, 0, 0, 2'b10, 32'h0, 32'h0);
        @(negedge clk);
        chk("oob_resp", dmem_resp, 2'b10);
        chk("ierr_ack", imem_req_ack, 1);
        chk("ierr_en", ram_en, 0);
        drv(1, 32'h10, 0, 0, 2'b10, 32'h0, 32'h0);
        @(negedge clk);
        chk("ierr_resp", imem_resp, 2'b10);
        idle();
        @(negedge clk);
        chk("if_resp", imem_resp, 2'b01);
        chk("if_data", imem_rdata, 32'hA5ADBEEF);

        drv(0, 0, 1, 0, 2'b11, 32'h20, 32'h0);
        @(negedge clk);
        chk("w3_en", ram_en, 0);
        idle();
        @(negedge clk);
        chk("w3_resp", dmem_resp, 2'b10);

        for (int c = 1; c <= 12; c++) begin
            contend();
            @(negedge clk);
            chk("cont_iack", imem_req_ack, (c == 5 || c == 10));
            chk("cont_dack", dmem_req_ack, !(c == 5 || c == 10));
        end
        idle();

        for (int c = 0; c < 3; c++) contend();
        contend(); rst = 1;
        @(negedge clk);
        chk("rsta_dresp", dmem_resp, 2'b00);
        chk("rsta_ack", dmem_req_ack, 0);
        for (int c = 1; c <= 5; c++) begin
            contend(); rst = 0;
            @(negedge clk);
            chk("rsta_iack", imem_req_ack, (c == 5));
        end
        idle();

        drv(0, 0, 1, 0, 2'b10, 32'h10, 32'h0);
        idle(); rst = 1;
        @(negedge clk);
        chk("rstb_dresp", dmem_resp, 2'b00);
        drv(1, 32'h10, 0, 0, 2'b10, 32'h0, 32'h0); rst = 0;
        @(negedge clk);
        chk("rstb_iack", imem_req_ack, 1);
        idle();
        @(negedge clk);
        chk("rstb_iresp", imem_resp, 2'b01);
        chk("rstb_dresp2", dmem_resp, 2'b00);
        idle();
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
